// File: rtl/sopc_anemo_inputs_irq.sv
// Avalon-MM parallel input port with edge capture and a maskable level interrupt.
// Inputs are synchronised before use; edge detection is held off until the sync chain has flushed after reset.
module sopc_anemo_inputs_irq #(
  parameter int WIDTH       = 3,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_d;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [31:0]      rd_mux;
  logic             wr_en;

  assign sync_q = sync_chain[SYNC_STAGES-1];
  assign armed  = (arm_cnt == ARM_DONE);
  assign wr_en  = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_chain[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
      sync_d <= sync_q;
    end
  end

  // Counts edges since reset release so the all-zero chain flushing out is never seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_hit = sync_q & ~sync_d;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~sync_q & sync_d;
    end else begin
      edge_hit = sync_q ^ sync_d;
    end
  end

  assign cap_set = armed ? edge_hit : '0;
  assign cap_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // Set is ORed in after the clear so a simultaneous new edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      edgecapture <= (edgecapture & ~cap_clr) | cap_set;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = 32'(sync_q);
      2'd2:    rd_mux = 32'(irqmask);
      2'd3:    rd_mux = 32'(edgecapture);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_sopc_anemo_inputs_irq.sv
// Directed bench: one instance per EDGE_TYPE sharing clock, reset and bus.
module tb_sopc_anemo_inputs_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [2:0]  in0 = 3'b111, in1 = 3'b111, in2 = 3'b111;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sopc_anemo_inputs_irq #(.WIDTH(3), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
  sopc_anemo_inputs_irq #(.WIDTH(3), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
  sopc_anemo_inputs_irq #(.WIDTH(3), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
  endtask

  initial begin
    // reset with inputs held high, no capture from release
    #2 reset_n = 1'b0;
    ticks(3);
    check("rst_readdata", rd0, 32'd0);
    check("rst_irq", {31'd0, irq0}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) check("rel_irq", {29'd0, irq0, irq1, irq2}, 32'd0);
    ticks(4);
    rd(2'd0);
    check("rel_data", rd0, 32'd7);
    rd(2'd2);
    check("rel_mask", rd0, 32'd0);
    rd(2'd3);
    check("rel_cap_rise", rd0, 32'd0);
    check("rel_cap_any", rd2, 32'd0);
    check("rel_irq_end", {29'd0, irq0, irq1, irq2}, 32'd0);

    // rising-edge capture latency and write-1-to-clear
    in0 = 3'b000;
    ticks(4);
    wr(2'd2, 32'd2);
    address = 2'd3;
    in0 = 3'b010;
    tick();
    check("rise_irq_e1", {31'd0, irq0}, 32'd0);
    tick();
    check("rise_irq_e2", {31'd0, irq0}, 32'd0);
    tick();
    check("rise_irq_e3", {31'd0, irq0}, 32'd1);
    check("rise_rd_e3", rd0, 32'd0);
    tick();
    check("rise_cap", rd0, 32'd2);
    wr(2'd3, 32'd2);
    check("clr_irq", {31'd0, irq0}, 32'd0);
    tick();
    check("clr_cap", rd0, 32'd0);

    // falling-edge capture with mask gating irq
    in1 = 3'b101;
    do_reset();
    ticks(5);
    rd(2'd3);
    check("fall_cap_idle", rd1, 32'd0);
    in1 = 3'b000;
    ticks(4);
    rd(2'd3);
    check("fall_cap", rd1, 32'd5);
    check("fall_irq_masked", {31'd0, irq1}, 32'd0);
    wr(2'd2, 32'd4);
    check("fall_irq_unmasked", {31'd0, irq1}, 32'd1);
    rd(2'd2);
    check("fall_mask", rd1, 32'd4);

    // any-edge: set beats a simultaneous clear
    in2 = 3'b000;
    do_reset();
    ticks(5);
    in2 = 3'b001;
    ticks(4);
    rd(2'd3);
    check("any_cap_rise", rd2, 32'd1);
    in2 = 3'b000;
    ticks(2);
    wr(2'd3, 32'd1);
    rd(2'd3);
    check("any_set_wins", rd2, 32'd1);
    wr(2'd3, 32'd1);
    rd(2'd3);
    check("any_clr_plain", rd2, 32'd0);

    // register map: mask width, ignored addresses, side-effect-free reads
    in0 = 3'b000;
    do_reset();
    ticks(5);
    in0 = 3'b101;
    ticks(4);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    check("mask_trunc", rd0, 32'h0000_0007);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0);
    rd(2'd0);
    check("data_after_wr", rd0, 32'd5);
    rd(2'd1);
    check("reserved_zero", rd0, 32'd0);
    rd(2'd2);
    check("mask_after_wr", rd0, 32'd7);
    rd(2'd3);
    check("cap_after_wr", rd0, 32'd5);
    rd(2'd3);
    check("cap_reread", rd0, 32'd5);
    check("irq_before_rst", {31'd0, irq0}, 32'd1);

    // asynchronous reset mid-operation
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_irq", {31'd0, irq0}, 32'd0);
    check("async_rd", rd0, 32'd0);
    ticks(2);
    reset_n = 1'b1;
    ticks(6);
    rd(2'd3);
    check("post_rst_cap", rd0, 32'd0);
    rd(2'd2);
    check("post_rst_mask", rd0, 32'd0);
    check("post_rst_irq", {31'd0, irq0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sopc_anemo_inputs_irq.md
SOPC_ANEMO_INPUTS_IRQ -- requirements
Module: sopc_anemo_inputs_irq

Interface
REQ-001 Parameters SHALL be exactly these, one per line: name, default, meaning.
- WIDTH, 3, number of input bits (1..32).
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, synchroniser depth on in_port (2..4).

REQ-002 Ports SHALL be exactly these, one per line: name, direction, width, meaning.
- clk, input, 1, single system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, Avalon-MM slave word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- in_port, input, WIDTH, asynchronous external inputs.
- readdata, output, 32, registered read data.
- irq, output, 1, active-high level interrupt.

REQ-003 The block SHALL have exactly one clock, clk, and one reset, reset_n, which is asynchronous and active-low.

Function
REQ-004 Register map (word address):
- 0: data, read-only, the synchronised inputs.
- 1: reserved, reads 0, writes ignored.
- 2: irqmask, read/write, WIDTH bits.
- 3: edgecapture, read, write-1-to-clear.

REQ-005 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the chain output is sync_q, and a further flop holds sync_d (sync_q delayed one cycle).

REQ-006 An edge on bit i SHALL be detected as follows:
- EDGE_TYPE 0: sync_q[i] & ~sync_d[i].
- EDGE_TYPE 1: ~sync_q[i] & sync_d[i].
- EDGE_TYPE 2: sync_q[i] ^ sync_d[i].

REQ-007 Edge detection SHALL be disarmed after reset until SYNC_STAGES+1 clock edges have occurred; this is tracked by a saturating arm counter. While disarmed, no edgecapture bit SHALL set.

REQ-008 A detected edge SHALL set edgecapture[i] on the next clk edge; the bit SHALL hold until cleared.

REQ-009 A write is chipselect=1 and write_n=0, and it SHALL take effect on the same clk edge.

REQ-010 A write to address 3 SHALL clear each edgecapture[i] whose writedata[i]=1; bits with writedata[i]=0 SHALL be unaffected.

REQ-011 If a set and a clear of the same edgecapture bit occur in the same cycle, the set SHALL win and the bit SHALL read 1.

REQ-012 A write to address 2 SHALL load irqmask with writedata[WIDTH-1:0]; upper writedata bits SHALL be ignored.

REQ-013 Writes to addresses 0 and 1 SHALL have no effect.

REQ-014 readdata SHALL update on every clk edge, regardless of chipselect, with the selected register zero-extended to 32 bits. Read latency is 1 cycle from address.

REQ-015 Reads SHALL have no side effects; in particular, reading edgecapture SHALL not clear it.

REQ-016 irq SHALL equal OR-reduce(edgecapture & irqmask), decoded combinationally from registers only, with no path from in_port or the bus inputs.

REQ-017 Input-to-data latency: an in_port change SHALL be visible at data SYNC_STAGES cycles after the first sampling edge, and in readdata one cycle later.

REQ-018 Input-to-capture latency: edgecapture SHALL set SYNC_STAGES+1 cycles after the first sampling edge of the input change.

REQ-019 Input pulses shorter than one clk period MAY be missed; no requirement applies to them.

Reset
REQ-020 While reset_n=0, all of the following SHALL be 0 asynchronously: the sync chain, sync_d, the arm counter, irqmask, edgecapture, readdata and irq.

REQ-021 Reset asserted mid-operation SHALL discard pending captures and the mask; no edge SHALL be captured from the reset-release transition itself (see REQ-007).

REQ-022 reset_n deassertion is synchronous to clk, guaranteed externally.

Verification
REQ-023 The bench SHALL cover these directed scenarios (WIDTH=3, SYNC_STAGES=2 unless stated):
- Reset with in_port=3'b111 held, then release and read addr 0/2/3 -> readdata 7, 0, 0; irq=0 throughout.
- EDGE_TYPE=0, irqmask=3'b010, in_port 000->010 -> edgecapture=2 three cycles later; irq=1. Write 2 to addr 3 -> edgecapture=0, irq=0 next cycle.
- EDGE_TYPE=1, in_port 101->000 -> edgecapture=5. With irqmask=0, irq stays 0; write irqmask=4 -> irq=1.
- EDGE_TYPE=2, edge on bit0 in the same cycle as a write of 1 to addr 3 -> edgecapture[0] remains 1.
- Write 0xFFFFFFFF to addr 2 -> readdata=0x00000007. Write to addr 0 and addr 1 -> values unchanged, addr 1 reads 0.
- Assert reset_n mid-capture with irq=1 -> irq, readdata and edgecapture go to 0 immediately, without waiting for a clk edge.
